// File: rtl/seg7_scan_pkg.sv
// Shared constants and types for the seg7 display scan driver.
package seg7_scan_pkg;

    localparam logic SEG7_DIGIT_OFF = 1'b1;
    localparam int   SEG7_DW        = 4;
    localparam int   SEG7_DWELL_DEF = 50000;
    localparam int   SEG7_GUARD_DEF = 500;

    typedef enum logic {
        PH_GUARD = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

endpackage

// File: rtl/seg7_slot_timer.sv
// Per-digit slot counter with GUARD/SHOW phase FSM.
module seg7_slot_timer
    import seg7_scan_pkg::*;
#(
    parameter int DWELL_CYCLES = SEG7_DWELL_DEF,
    parameter int GUARD_CYCLES = SEG7_GUARD_DEF
) (
    input  logic   clk,
    input  logic   rst,
    output logic   slot_pre,
    output logic   slot_end,
    output logic   guard_end,
    output phase_t phase
);

    localparam int CW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] PRE  = CW'(DWELL_CYCLES - 2);
    localparam logic [CW-1:0] GEND = CW'(GUARD_CYCLES - 1);

    logic [CW-1:0] cnt;
    phase_t        phase_next;

    assign slot_end  = (cnt == LAST);
    assign slot_pre  = (cnt == PRE);
    assign guard_end = (phase == PH_GUARD) && (cnt == GEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= PH_GUARD;
        end else begin
            cnt   <= slot_end ? '0 : cnt + 1'b1;
            phase <= phase_next;
        end
    end

    always_comb begin
        phase_next = phase;
        unique case (phase)
            PH_GUARD: if (guard_end) phase_next = PH_SHOW;
            PH_SHOW:  if (slot_end)  phase_next = PH_GUARD;
            default:  phase_next = PH_GUARD;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scan driver with frame-synchronous value update
// and leading-zero blanking.
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int DWELL_CYCLES = SEG7_DWELL_DEF,
    parameter int GUARD_CYCLES = SEG7_GUARD_DEF
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Load,
    input  logic [SEG7_DW*DIGITS-1:0] Value_in,
    input  logic                      LZB_en,
    output logic [SEG7_DW-1:0]        Digital_to_display,
    output logic [DIGITS-1:0]         Digit_sel_n,
    output logic                      Frame_done,
    output logic                      Pending
);

    localparam int DW = SEG7_DW;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0]     LAST_IDX = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ALL_OFF  = {DIGITS{SEG7_DIGIT_OFF}};

    if (GUARD_CYCLES < 1 || GUARD_CYCLES >= DWELL_CYCLES || DWELL_CYCLES < 2)
    begin : g_bad_timing
        $error("seg7_scan: need 1 <= GUARD_CYCLES < DWELL_CYCLES");
    end

    logic                 slot_pre;
    logic                 slot_end;
    logic                 guard_end;
    phase_t               phase;
    logic [DW*DIGITS-1:0] active;
    logic [DW*DIGITS-1:0] pend_val;
    logic [DW*DIGITS-1:0] next_active;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        idx_next;
    logic [DIGITS-1:0]    lead_zero;
    logic                 blank;
    logic                 frame_end;

    seg7_slot_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_timer (
        .clk       (Clk),
        .rst       (Rst),
        .slot_pre  (slot_pre),
        .slot_end  (slot_end),
        .guard_end (guard_end),
        .phase     (phase)
    );

    assign frame_end = slot_end && (idx == LAST_IDX);

    // lead_zero[i]: digits DIGITS-1 down to i are all zero
    always_comb begin
        lead_zero = '0;
        lead_zero[DIGITS-1] = (active[DW*(DIGITS-1) +: DW] == '0);
        for (int i = DIGITS - 2; i >= 0; i--)
            lead_zero[i] = lead_zero[i+1] && (active[DW*i +: DW] == '0);
        blank       = LZB_en && (idx != '0) && lead_zero[idx];
        next_active = (frame_end && Pending) ? pend_val : active;
        idx_next    = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            active             <= '0;
            pend_val           <= '0;
            Pending            <= 1'b0;
            idx                <= '0;
            Digital_to_display <= '0;
            Digit_sel_n        <= ALL_OFF;
            Frame_done         <= 1'b0;
        end else begin
            if (Load)
                pend_val <= Value_in;
            if (frame_end && Pending)
                active <= pend_val;
            Pending    <= Load || (Pending && !frame_end);
            Frame_done <= slot_pre && (idx == LAST_IDX);
            if (slot_end) begin
                idx                <= idx_next;
                Digital_to_display <= next_active[DW*idx_next +: DW];
                Digit_sel_n        <= ALL_OFF;
            end else if (guard_end) begin
                Digit_sel_n <= blank ? ALL_OFF : ~(DIGITS'(1) << idx);
            end
        end
    end

    a_onehot0: assert property (@(posedge Clk) disable iff (Rst)
        $onehot0(~Digit_sel_n));
    a_fd_width: assert property (@(posedge Clk) disable iff (Rst)
        Frame_done |=> !Frame_done);
    a_guard_off: assert property (@(posedge Clk) disable iff (Rst)
        (phase == PH_GUARD) |-> (Digit_sel_n == ALL_OFF));

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan (4 digits, dwell 8, guard 2).
module tb_seg7_scan;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Load = 1'b0;
    logic [15:0] Value_in = '0;
    logic        LZB_en = 1'b0;
    logic [3:0]  Digital_to_display;
    logic [3:0]  Digit_sel_n;
    logic        Frame_done;
    logic        Pending;

    int tests = 0;
    int fails = 0;

    seg7_scan #(
        .DIGITS       (4),
        .DWELL_CYCLES (8),
        .GUARD_CYCLES (2)
    ) dut (
        .Clk                (Clk),
        .Rst                (Rst),
        .Load               (Load),
        .Value_in           (Value_in),
        .LZB_en             (LZB_en),
        .Digital_to_display (Digital_to_display),
        .Digit_sel_n        (Digit_sel_n),
        .Frame_done         (Frame_done),
        .Pending            (Pending)
    );

    always #5 Clk = ~Clk;

    // One-cycle Load strobe driven from a negedge.
    task automatic load_value(input logic [15:0] v);
        Load = 1'b1;
        Value_in = v;
        @(negedge Clk);
        Load = 1'b0;
    endtask

    // Advance until the Frame_done cycle, bounded.
    task automatic sync_frame();
        bit seen = 0;
        for (int n = 0; n < 64 && !seen; n++) begin
            @(negedge Clk);
            if (Frame_done === 1'b1) seen = 1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL sync_frame: Frame_done not seen within 64 cycles");
        end
    endtask

    // From a Frame_done cycle, record one full frame of slot codes/enables.
    task automatic capture_frame(output logic [15:0] codes,
                                 output logic [15:0] sels,
                                 output logic ok);
        ok = 1'b1;
        codes = '0;
        sels = '0;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 8; c++) begin
                @(negedge Clk);
                Load = 1'b0;
                if (c == 0) codes[4*s +: 4] = Digital_to_display;
                else if (Digital_to_display !== codes[4*s +: 4]) ok = 1'b0;
                if (c == 2) sels[4*s +: 4] = Digit_sel_n;
                if (c < 2 && Digit_sel_n !== 4'hF) ok = 1'b0;
                if (c > 2 && Digit_sel_n !== sels[4*s +: 4]) ok = 1'b0;
                if (Frame_done !== ((s == 3 && c == 7) ? 1'b1 : 1'b0)) ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_sel;
        logic       exp_fd;
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        tests += 4;
        if (Digit_sel_n !== 4'hF) begin
            fails++; $display("FAIL reset_sel: got %b want 1111", Digit_sel_n);
        end
        if (Digital_to_display !== 4'h0) begin
            fails++; $display("FAIL reset_code: got %h want 0", Digital_to_display);
        end
        if (Pending !== 1'b0) begin
            fails++; $display("FAIL reset_pending: got %b want 0", Pending);
        end
        if (Frame_done !== 1'b0) begin
            fails++; $display("FAIL reset_fd: got %b want 0", Frame_done);
        end
        Rst = 1'b0;
        for (int c = 0; c < 64; c++) begin
            if (c > 0) @(negedge Clk);
            exp_sel = ((c % 8) < 2) ? 4'hF : ~(4'b0001 << ((c / 8) % 4));
            exp_fd  = ((c % 32) == 31) ? 1'b1 : 1'b0;
            tests += 3;
            if (Digit_sel_n !== exp_sel) begin
                fails++;
                $display("FAIL scan_sel c=%0d: got %b want %b", c, Digit_sel_n, exp_sel);
            end
            if (Digital_to_display !== 4'h0) begin
                fails++;
                $display("FAIL scan_code c=%0d: got %h want 0", c, Digital_to_display);
            end
            if (Frame_done !== exp_fd) begin
                fails++;
                $display("FAIL scan_fd c=%0d: got %b want %b", c, Frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_basic_load();
        logic [15:0] codes, sels;
        logic ok;
        LZB_en = 1'b0;
        repeat (10) @(negedge Clk);
        load_value(16'h1234);
        tests++;
        if (Pending !== 1'b1) begin
            fails++; $display("FAIL basic_pend_rise: got %b want 1", Pending);
        end
        sync_frame();
        tests++;
        if (Pending !== 1'b1) begin
            fails++; $display("FAIL basic_pend_hold: got %b want 1", Pending);
        end
        capture_frame(codes, sels, ok);
        tests += 4;
        if (codes !== 16'h1234) begin
            fails++; $display("FAIL basic_codes: got %h want 1234", codes);
        end
        if (sels !== 16'h7BDE) begin
            fails++; $display("FAIL basic_sels: got %h want 7bde", sels);
        end
        if (ok !== 1'b1) begin
            fails++; $display("FAIL basic_stable: got %b want 1", ok);
        end
        if (Pending !== 1'b0) begin
            fails++; $display("FAIL basic_pend_clear: got %b want 0", Pending);
        end
    endtask

    task automatic test_blanking();
        logic [15:0] codes, sels;
        logic ok;
        LZB_en = 1'b1;
        load_value(16'h0105);
        sync_frame();
        capture_frame(codes, sels, ok);
        tests += 3;
        if (codes !== 16'h0105) begin
            fails++; $display("FAIL lzb0105_codes: got %h want 0105", codes);
        end
        if (sels !== 16'hFBDE) begin
            fails++; $display("FAIL lzb0105_sels: got %h want fbde", sels);
        end
        if (ok !== 1'b1) begin
            fails++; $display("FAIL lzb0105_stable: got %b want 1", ok);
        end
        load_value(16'h0000);
        sync_frame();
        capture_frame(codes, sels, ok);
        tests += 3;
        if (codes !== 16'h0000) begin
            fails++; $display("FAIL lzb0000_codes: got %h want 0000", codes);
        end
        if (sels !== 16'hFFFE) begin
            fails++; $display("FAIL lzb0000_sels: got %h want fffe", sels);
        end
        if (ok !== 1'b1) begin
            fails++; $display("FAIL lzb0000_stable: got %b want 1", ok);
        end
        repeat (4) @(negedge Clk);
        tests++;
        if (Digit_sel_n !== 4'hE) begin
            fails++; $display("FAIL lzb_slot0: got %b want 1110", Digit_sel_n);
        end
        LZB_en = 1'b0;
        repeat (7) @(negedge Clk);
        tests++;
        if (Digit_sel_n !== 4'hD) begin
            fails++; $display("FAIL lzb_off_slot1: got %b want 1101", Digit_sel_n);
        end
        sync_frame();
    endtask

    task automatic test_load_at_transfer();
        logic [15:0] codes, sels;
        logic ok;
        LZB_en = 1'b0;
        load_value(16'h1111);
        sync_frame();
        Load = 1'b1;
        Value_in = 16'h2222;
        capture_frame(codes, sels, ok);
        tests += 4;
        if (codes !== 16'h1111) begin
            fails++; $display("FAIL xfer_first_codes: got %h want 1111", codes);
        end
        if (sels !== 16'h7BDE) begin
            fails++; $display("FAIL xfer_first_sels: got %h want 7bde", sels);
        end
        if (ok !== 1'b1) begin
            fails++; $display("FAIL xfer_first_stable: got %b want 1", ok);
        end
        if (Pending !== 1'b1) begin
            fails++; $display("FAIL xfer_pend_kept: got %b want 1", Pending);
        end
        capture_frame(codes, sels, ok);
        tests += 2;
        if (codes !== 16'h2222) begin
            fails++; $display("FAIL xfer_second_codes: got %h want 2222", codes);
        end
        if (Pending !== 1'b0) begin
            fails++; $display("FAIL xfer_pend_clear: got %b want 0", Pending);
        end
    endtask

    task automatic test_overwrite();
        logic [15:0] codes, sels;
        logic ok;
        load_value(16'h0930);
        repeat (3) @(negedge Clk);
        load_value(16'h0931);
        sync_frame();
        capture_frame(codes, sels, ok);
        tests += 3;
        if (codes !== 16'h0931) begin
            fails++; $display("FAIL ovw_codes: got %h want 0931", codes);
        end
        if (sels !== 16'h7BDE) begin
            fails++; $display("FAIL ovw_sels: got %h want 7bde", sels);
        end
        if (Pending !== 1'b0) begin
            fails++; $display("FAIL ovw_pend: got %b want 0", Pending);
        end
    endtask

    task automatic test_mid_slot_reset();
        repeat (21) @(negedge Clk);
        tests += 2;
        if (Digit_sel_n !== 4'hB) begin
            fails++; $display("FAIL mrst_pre_sel: got %b want 1011", Digit_sel_n);
        end
        if (Digital_to_display !== 4'h9) begin
            fails++; $display("FAIL mrst_pre_code: got %h want 9", Digital_to_display);
        end
        #2 Rst = 1'b1;
        #1;
        tests += 3;
        if (Digit_sel_n !== 4'hF) begin
            fails++; $display("FAIL mrst_async_sel: got %b want 1111", Digit_sel_n);
        end
        if (Digital_to_display !== 4'h0) begin
            fails++; $display("FAIL mrst_async_code: got %h want 0", Digital_to_display);
        end
        if (Pending !== 1'b0) begin
            fails++; $display("FAIL mrst_async_pend: got %b want 0", Pending);
        end
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        tests += 2;
        if (Digit_sel_n !== 4'hE) begin
            fails++; $display("FAIL mrst_slot0_sel: got %b want 1110", Digit_sel_n);
        end
        if (Digital_to_display !== 4'h0) begin
            fails++; $display("FAIL mrst_slot0_code: got %h want 0", Digital_to_display);
        end
        repeat (8) @(negedge Clk);
        tests += 2;
        if (Digit_sel_n !== 4'hD) begin
            fails++; $display("FAIL mrst_slot1_sel: got %b want 1101", Digit_sel_n);
        end
        if (Digital_to_display !== 4'h0) begin
            fails++; $display("FAIL mrst_slot1_code: got %h want 0", Digital_to_display);
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_blanking();
        test_load_at_transfer();
        test_overwrite();
        test_mid_slot_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
